// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU-op encodings, immediate formats
// and the control bundle carried through ID/EX.
package riscv_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_BRANCH = 2'b01,
    ALU_FUNCT  = 2'b10,
    ALU_IMM    = 2'b11
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic    src_a;
    logic    src_b;
    alu_op_e alu_op;
    logic    mem_read;
    logic    mem_write;
    logic    reg_write;
    logic    mem_to_reg;
    logic    branch;
    logic    jump;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [XLEN-1:0] imm;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'h000};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {XLEN{1'b0}};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/register_file.sv
// 32x32 register file: two combinational read ports with write-through bypass,
// one write port, x0 hardwired to zero, cleared by synchronous active-low reset.
module register_file
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  output logic [XLEN-1:0] o_rs1_data,
  output logic [XLEN-1:0] o_rs2_data,
  input  logic            i_we,
  input  logic [4:0]      i_rd,
  input  logic [XLEN-1:0] i_wd
);

  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic            w_wr_en;

  assign w_wr_en = i_we && (i_rd != 5'd0);

  // Storage update: clear on reset, otherwise accept writeback (never to x0).
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
    end else if (w_wr_en) begin
      r_regs[i_rd] <= i_wd;
    end
  end

  // Read ports: x0 reads zero, same-cycle writeback wins over stored value.
  always_comb begin
    o_rs1_data = {XLEN{1'b0}};
    o_rs2_data = {XLEN{1'b0}};
    if (i_rs1 == 5'd0) begin
      o_rs1_data = {XLEN{1'b0}};
    end else if (w_wr_en && (i_rd == i_rs1)) begin
      o_rs1_data = i_wd;
    end else begin
      o_rs1_data = r_regs[i_rs1];
    end
    if (i_rs2 == 5'd0) begin
      o_rs2_data = {XLEN{1'b0}};
    end else if (w_wr_en && (i_rd == i_rs2)) begin
      o_rs2_data = i_wd;
    end else begin
      o_rs2_data = r_regs[i_rs2];
    end
  end

endmodule

// File: rtl/instruction_decode_stage.sv
// RV32I decode stage: control/immediate decode, register read, load-use hazard
// detection and the ID/EX pipeline register.
module instruction_decode_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [XLEN-1:0] i_if_id_pc,
  input  logic [31:0]     i_if_id_instruction,
  input  logic            i_wb_reg_write,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_flush,
  output logic            o_stall,
  output logic [XLEN-1:0] o_id_ex_pc,
  output logic [XLEN-1:0] o_id_ex_rs1_data,
  output logic [XLEN-1:0] o_id_ex_rs2_data,
  output logic [XLEN-1:0] o_id_ex_imm,
  output logic [4:0]      o_id_ex_rs1,
  output logic [4:0]      o_id_ex_rs2,
  output logic [4:0]      o_id_ex_rd,
  output logic [2:0]      o_id_ex_funct3,
  output logic            o_id_ex_funct7b5,
  output logic            o_id_ex_alu_src_a,
  output logic            o_id_ex_alu_src_b,
  output logic [1:0]      o_id_ex_alu_op,
  output logic            o_id_ex_mem_read,
  output logic            o_id_ex_mem_write,
  output logic            o_id_ex_reg_write,
  output logic            o_id_ex_mem_to_reg,
  output logic            o_id_ex_branch,
  output logic            o_id_ex_jump,
  output logic            o_id_ex_valid
);
  import riscv_pkg::*;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data;
  ctrl_t           w_ctrl;
  imm_fmt_e        w_imm_fmt;
  logic            w_legal, w_uses_rs1, w_uses_rs2, w_stall, w_bubble;

  ctrl_t           r_ctrl;
  logic            r_valid;
  logic [XLEN-1:0] r_pc, r_rs1_data, r_rs2_data, r_imm;
  logic [4:0]      r_rs1, r_rs2, r_rd;
  logic [2:0]      r_funct3;
  logic            r_funct7b5;

  assign w_opcode = i_if_id_instruction[6:0];
  assign w_rd     = i_if_id_instruction[11:7];
  assign w_rs1    = i_if_id_instruction[19:15];
  assign w_rs2    = i_if_id_instruction[24:20];

  register_file #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_regfile (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_rs1      (w_rs1),
    .i_rs2      (w_rs2),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_we       (i_wb_reg_write),
    .i_rd       (i_wb_rd),
    .i_wd       (i_wb_data)
  );

  // Opcode decode: controls, immediate format and which source registers are read.
  always_comb begin
    w_ctrl     = CTRL_NOP;
    w_imm_fmt  = IMM_NONE;
    w_legal    = 1'b1;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_ctrl.alu_op = ALU_FUNCT; w_ctrl.reg_write = 1'b1;
        w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
      end
      OP_I_ALU: begin
        w_ctrl.alu_op = ALU_FUNCT; w_ctrl.src_b = 1'b1; w_ctrl.reg_write = 1'b1;
        w_imm_fmt = IMM_I; w_uses_rs1 = 1'b1;
      end
      OP_LOAD: begin
        w_ctrl.src_b = 1'b1; w_ctrl.mem_read = 1'b1; w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.reg_write = 1'b1; w_imm_fmt = IMM_I; w_uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        w_ctrl.src_b = 1'b1; w_ctrl.mem_write = 1'b1;
        w_imm_fmt = IMM_S; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        w_ctrl.alu_op = ALU_BRANCH; w_ctrl.branch = 1'b1;
        w_imm_fmt = IMM_B; w_uses_rs1 = 1'b1; w_uses_rs2 = 1'b1;
      end
      OP_JAL: begin
        w_ctrl.src_a = 1'b1; w_ctrl.src_b = 1'b1; w_ctrl.jump = 1'b1;
        w_ctrl.reg_write = 1'b1; w_imm_fmt = IMM_J;
      end
      OP_JALR: begin
        w_ctrl.src_b = 1'b1; w_ctrl.jump = 1'b1; w_ctrl.reg_write = 1'b1;
        w_imm_fmt = IMM_I; w_uses_rs1 = 1'b1;
      end
      OP_LUI: begin
        w_ctrl.alu_op = ALU_IMM; w_ctrl.src_b = 1'b1; w_ctrl.reg_write = 1'b1;
        w_imm_fmt = IMM_U;
      end
      OP_AUIPC: begin
        w_ctrl.src_a = 1'b1; w_ctrl.src_b = 1'b1; w_ctrl.reg_write = 1'b1;
        w_imm_fmt = IMM_U;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Flush outranks the hazard: a squashed instruction cannot stall fetch.
  assign w_stall = !i_flush && r_valid && r_ctrl.mem_read && (r_rd != 5'd0) &&
                   ((w_uses_rs1 && (w_rs1 == r_rd)) || (w_uses_rs2 && (w_rs2 == r_rd)));
  assign w_bubble = i_flush || w_stall || !w_legal;
  assign o_stall  = w_stall;

  // ID/EX pipeline register; a bubble zeroes every control bit and valid.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_ctrl     <= CTRL_NOP;
      r_valid    <= 1'b0;
      r_pc       <= {XLEN{1'b0}};
      r_rs1_data <= {XLEN{1'b0}};
      r_rs2_data <= {XLEN{1'b0}};
      r_imm      <= {XLEN{1'b0}};
      r_rs1      <= 5'd0;
      r_rs2      <= 5'd0;
      r_rd       <= 5'd0;
      r_funct3   <= 3'd0;
      r_funct7b5 <= 1'b0;
    end else begin
      r_pc       <= i_if_id_pc;
      r_rs1_data <= w_rs1_data;
      r_rs2_data <= w_rs2_data;
      r_imm      <= gen_imm(i_if_id_instruction, w_imm_fmt);
      r_rs1      <= w_rs1;
      r_rs2      <= w_rs2;
      r_rd       <= w_rd;
      r_funct3   <= i_if_id_instruction[14:12];
      r_funct7b5 <= i_if_id_instruction[30];
      if (w_bubble) begin
        r_ctrl  <= CTRL_NOP;
        r_valid <= 1'b0;
      end else begin
        r_ctrl  <= w_ctrl;
        r_valid <= 1'b1;
      end
    end
  end

  assign o_id_ex_pc         = r_pc;
  assign o_id_ex_rs1_data   = r_rs1_data;
  assign o_id_ex_rs2_data   = r_rs2_data;
  assign o_id_ex_imm        = r_imm;
  assign o_id_ex_rs1        = r_rs1;
  assign o_id_ex_rs2        = r_rs2;
  assign o_id_ex_rd         = r_rd;
  assign o_id_ex_funct3     = r_funct3;
  assign o_id_ex_funct7b5   = r_funct7b5;
  assign o_id_ex_alu_src_a  = r_ctrl.src_a;
  assign o_id_ex_alu_src_b  = r_ctrl.src_b;
  assign o_id_ex_alu_op     = r_ctrl.alu_op;
  assign o_id_ex_mem_read   = r_ctrl.mem_read;
  assign o_id_ex_mem_write  = r_ctrl.mem_write;
  assign o_id_ex_reg_write  = r_ctrl.reg_write;
  assign o_id_ex_mem_to_reg = r_ctrl.mem_to_reg;
  assign o_id_ex_branch     = r_ctrl.branch;
  assign o_id_ex_jump       = r_ctrl.jump;
  assign o_id_ex_valid      = r_valid;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Self-checking bench: vector table + scoreboard queue, plus hand sequences for
// flush-vs-hazard and reset during a stall.
module tb_instruction_decode_stage;

  logic        clk = 1'b0;
  logic        i_reset, i_wb_reg_write, i_flush;
  logic [31:0] i_if_id_pc, i_if_id_instruction, i_wb_data;
  logic [4:0]  i_wb_rd;
  logic        o_stall, o_funct7b5, o_src_a, o_src_b, o_mem_read, o_mem_write;
  logic        o_reg_write, o_mem_to_reg, o_branch, o_jump, o_valid;
  logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [2:0]  o_funct3;
  logic [1:0]  o_alu_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_decode_stage dut (
    .i_clk(clk), .i_reset(i_reset), .i_if_id_pc(i_if_id_pc),
    .i_if_id_instruction(i_if_id_instruction), .i_wb_reg_write(i_wb_reg_write),
    .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data), .i_flush(i_flush), .o_stall(o_stall),
    .o_id_ex_pc(o_pc), .o_id_ex_rs1_data(o_rs1_data), .o_id_ex_rs2_data(o_rs2_data),
    .o_id_ex_imm(o_imm), .o_id_ex_rs1(o_rs1), .o_id_ex_rs2(o_rs2), .o_id_ex_rd(o_rd),
    .o_id_ex_funct3(o_funct3), .o_id_ex_funct7b5(o_funct7b5),
    .o_id_ex_alu_src_a(o_src_a), .o_id_ex_alu_src_b(o_src_b), .o_id_ex_alu_op(o_alu_op),
    .o_id_ex_mem_read(o_mem_read), .o_id_ex_mem_write(o_mem_write),
    .o_id_ex_reg_write(o_reg_write), .o_id_ex_mem_to_reg(o_mem_to_reg),
    .o_id_ex_branch(o_branch), .o_id_ex_jump(o_jump), .o_id_ex_valid(o_valid)
  );

  // Control word layout: {src_a, src_b, alu_op[1:0], mem_read, mem_write, reg_write, mem_to_reg, branch, jump}
  localparam logic [9:0] C_R     = 10'b0_0_10_0_0_1_0_0_0;
  localparam logic [9:0] C_I     = 10'b0_1_10_0_0_1_0_0_0;
  localparam logic [9:0] C_LD    = 10'b0_1_00_1_0_1_1_0_0;
  localparam logic [9:0] C_ST    = 10'b0_1_00_0_1_0_0_0_0;
  localparam logic [9:0] C_BR    = 10'b0_0_01_0_0_0_0_1_0;
  localparam logic [9:0] C_JAL   = 10'b1_1_00_0_0_1_0_0_1;
  localparam logic [9:0] C_JALR  = 10'b0_1_00_0_0_1_0_0_1;
  localparam logic [9:0] C_LUI   = 10'b0_1_11_0_0_1_0_0_0;
  localparam logic [9:0] C_AUIPC = 10'b1_1_00_0_0_1_0_0_0;
  localparam logic [9:0] C_NONE  = 10'b0;

  typedef struct {
    logic [31:0] instr, pc;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush, e_stall, e_valid;
    logic [9:0]  e_ctrl;
    logic [31:0] e_imm;
    logic [4:0]  e_rd, e_rs1, e_rs2;
    logic [31:0] e_rs1d, e_rs2d;
  } vec_t;

  vec_t sb[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic [31:0] instr, pc, input logic wb_we,
                              input logic [4:0] wb_rd, input logic [31:0] wb_data,
                              input logic flush, e_stall, e_valid, input logic [9:0] e_ctrl,
                              input logic [31:0] e_imm, input logic [4:0] e_rd, e_rs1, e_rs2,
                              input logic [31:0] e_rs1d, e_rs2d);
    vec_t v;
    v.instr = instr; v.pc = pc; v.wb_we = wb_we; v.wb_rd = wb_rd; v.wb_data = wb_data;
    v.flush = flush; v.e_stall = e_stall; v.e_valid = e_valid; v.e_ctrl = e_ctrl;
    v.e_imm = e_imm; v.e_rd = e_rd; v.e_rs1 = e_rs1; v.e_rs2 = e_rs2;
    v.e_rs1d = e_rs1d; v.e_rs2d = e_rs2d;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare(input vec_t e);
    logic [9:0] ctrl;
    ctrl = {o_src_a, o_src_b, o_alu_op, o_mem_read, o_mem_write, o_reg_write,
            o_mem_to_reg, o_branch, o_jump};
    check("valid", {31'd0, o_valid}, {31'd0, e.e_valid});
    if (e.e_valid) begin
      check("ctrl", {22'd0, ctrl}, {22'd0, e.e_ctrl});
      check("imm", o_imm, e.e_imm);
      check("pc", o_pc, e.pc);
      check("rd", {27'd0, o_rd}, {27'd0, e.e_rd});
      check("rs1", {27'd0, o_rs1}, {27'd0, e.e_rs1});
      check("rs2", {27'd0, o_rs2}, {27'd0, e.e_rs2});
      check("rs1_data", o_rs1_data, e.e_rs1d);
      check("rs2_data", o_rs2_data, e.e_rs2d);
    end else begin
      check("bubble_ctrl", {26'd0, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg,
                            o_branch, o_jump}, 32'd0);
    end
  endtask

  task automatic drive(input vec_t v);
    i_if_id_instruction = v.instr; i_if_id_pc = v.pc; i_wb_reg_write = v.wb_we;
    i_wb_rd = v.wb_rd; i_wb_data = v.wb_data; i_flush = v.flush;
  endtask

  task automatic deliver();
    vec_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: got empty queue expected one entry");
    end else begin
      e = sb.pop_front();
      compare(e);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    check("stall", {31'd0, o_stall}, {31'd0, v.e_stall});
    sb.push_back(v);
    @(posedge clk);
    #1;
    deliver();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
    check({tag, "_ctrl"}, {22'd0, o_src_a, o_src_b, o_alu_op, o_mem_read, o_mem_write,
                           o_reg_write, o_mem_to_reg, o_branch, o_jump}, 32'd0);
    check({tag, "_pc"}, o_pc, 32'd0);
    check({tag, "_imm"}, o_imm, 32'd0);
    check({tag, "_rs1_data"}, o_rs1_data, 32'd0);
    check({tag, "_rs2_data"}, o_rs2_data, 32'd0);
    check({tag, "_idx"}, {17'd0, o_rs1, o_rs2, o_rd}, 32'd0);
    check({tag, "_stall"}, {31'd0, o_stall}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v_lw, v_add_dep, v_add_flush, v_add6;
    i_reset = 1'b0; i_flush = 1'b0; i_wb_reg_write = 1'b0; i_wb_rd = 5'd0;
    i_wb_data = 32'd0; i_if_id_pc = 32'd0; i_if_id_instruction = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset");
    @(negedge clk);
    i_reset = 1'b1;

    //          instr         pc      we rd  wb_data      fl st va ctrl     imm           rd  rs1 rs2 rs1d          rs2d
    tbl.push_back(mk(32'h00500093, 32'h00, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_I, 32'd5, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0));
    tbl.push_back(mk(32'h00028333, 32'h04, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, C_R, 32'd0, 5'd6, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(32'h00028333, 32'h08, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_R, 32'd0, 5'd6, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0));
    tbl.push_back(mk(32'h00700433, 32'h0C, 1'b1, 5'd7, 32'hCAFEF00D, 1'b0, 1'b0, 1'b1, C_R, 32'd0, 5'd8, 5'd0, 5'd7, 32'h0, 32'hCAFEF00D));
    tbl.push_back(mk(32'h00000013, 32'h10, 1'b1, 5'd0, 32'h1234, 1'b0, 1'b0, 1'b1, C_I, 32'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0));
    tbl.push_back(mk(32'h00000033, 32'h14, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_R, 32'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0));
    tbl.push_back(mk(32'hFE000EE3, 32'h18, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_BR, 32'hFFFFFFFC, 5'd29, 5'd0, 5'd0, 32'h0, 32'h0));
    tbl.push_back(mk(32'h001000EF, 32'h1C, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_JAL, 32'h00000800, 5'd1, 5'd0, 5'd1, 32'h0, 32'h0));
    tbl.push_back(mk(32'h123450B7, 32'h20, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_LUI, 32'h12345000, 5'd1, 5'd8, 5'd3, 32'h0, 32'h0));
    tbl.push_back(mk(32'h00001097, 32'h24, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_AUIPC, 32'h00001000, 5'd1, 5'd0, 5'd0, 32'h0, 32'h0));
    tbl.push_back(mk(32'h0020A223, 32'h28, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_ST, 32'd4, 5'd4, 5'd1, 5'd2, 32'h0, 32'h0));
    tbl.push_back(mk(32'h0020A223, 32'h2C, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, C_NONE, 32'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0));
    tbl.push_back(mk(32'h0000007F, 32'h30, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, C_NONE, 32'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0));
    tbl.push_back(mk(32'h000080E7, 32'h34, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_JALR, 32'd0, 5'd1, 5'd1, 5'd0, 32'h0, 32'h0));
    tbl.push_back(mk(32'h0000A103, 32'h38, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_LD, 32'd0, 5'd2, 5'd1, 5'd0, 32'h0, 32'h0));
    tbl.push_back(mk(32'h001101B3, 32'h3C, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 1'b0, C_NONE, 32'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0));
    tbl.push_back(mk(32'h001101B3, 32'h3C, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_R, 32'd0, 5'd3, 5'd2, 5'd1, 32'h0, 32'h0));

    foreach (tbl[i]) apply(tbl[i]);

    // Flush together with a load-use dependency: no stall, bubble inserted.
    v_lw        = tbl[14];
    v_add_flush = mk(32'h001101B3, 32'h40, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0, C_NONE, 32'd0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0);
    apply(v_lw);
    apply(v_add_flush);

    // Reset asserted while a load-use stall is active.
    apply(v_lw);
    v_add_dep = tbl[15];
    @(negedge clk);
    drive(v_add_dep);
    #1;
    check("stall_before_reset", {31'd0, o_stall}, 32'd1);
    i_reset = 1'b0;
    @(posedge clk);
    #1;
    check_cleared("midreset");
    @(negedge clk);
    i_reset = 1'b1;
    // Register file must have been cleared: x5 no longer holds 0xDEADBEEF.
    v_add6 = mk(32'h00028333, 32'h50, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, C_R, 32'd0, 5'd6, 5'd5, 5'd0, 32'h0, 32'h0);
    apply(v_add6);

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
